pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch/decode/execute control FSM that sequences the 8-bit program counter, instruction register and accumulator of the microprocessor datapath. It is the sole driver of the PC's LOAD_PC and INCR_PC strobes. It runs a memory read handshake for each fetch, decodes a 4-bit opcode, and issues single-cycle datapath strobes. It also maintains a fetch watchdog and a retired-instruction counter.

## Interface
Parameters:
- TIMEOUT, 15: maximum cycles FETCH waits for mem_ack before faulting (1..255).

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; forces IDLE and all outputs/counters to 0 immediately.
- run  input  1  level enable; starts execution from IDLE, sampled at end of EXEC.
- mem_ack  input  1  memory read data valid for current fetch.
- op  input  4  opcode field (IR[7:4]) from the instruction register.
- zero  input  1  accumulator-zero flag from the datapath.
- mem_req  output  1  fetch read request; high for every FETCH cycle.
- LOAD_IR  output  1  one-cycle strobe: capture memory data into IR.
- INCR_PC  output  1  one-cycle strobe to PC increment input.
- LOAD_PC  output  1  one-cycle strobe to PC load input (target = IR[3:0] zero-extended, muxed by datapath).
- LOAD_ACC  output  1  one-cycle strobe: write ALU result to accumulator.
- alu_op  output  3  ALU function, valid while LOAD_ACC high, else 0.
- halted  output  1  high in HALT state.
- fault  output  1  sticky: illegal opcode or fetch timeout; cleared only by reset.
- retired  output  8  count of instructions completing EXEC.

## Operation
States: IDLE, FETCH, DECODE, EXEC, HALT. The encoding is free.
- IDLE: all strobes low. run=1 -> FETCH next cycle.
- FETCH: mem_req=1. If mem_ack=1, assert LOAD_IR and INCR_PC in the same cycle, clear the watchdog, and go to DECODE. Otherwise increment the watchdog. When the watchdog reaches TIMEOUT without ack, set fault, go to HALT, and do not assert INCR_PC.
- DECODE: one cycle, no strobes. op is stable here and is registered for EXEC.
- EXEC: action per the registered opcode:
  - 0x0 NOP: no strobe.
  - 0x1–0x7 ALU: LOAD_ACC=1, alu_op=op[2:0].
  - 0x8 JMP: LOAD_PC=1.
  - 0x9 JZ: LOAD_PC=zero.
  - 0xA JNZ: LOAD_PC=~zero.
  - 0xF HLT: go to HALT. retired increments, fault stays 0.
  - 0xB–0xE illegal: set fault, go to HALT, retired does not increment.
- Leaving EXEC (non-halting opcodes): retired increments by 1. Next state is FETCH if run=1, else IDLE.
- HALT: absorbing; halted=1, all strobes low; only reset exits.
- Invariants:
  - LOAD_PC and INCR_PC are never high in the same cycle.
  - Each strobe is high for at most one cycle per instruction.
- retired is an 8-bit counter that wraps 255 -> 0 with no flag.
- The watchdog is ceil(log2(TIMEOUT+1)) bits wide and saturates; it never wraps.

## Timing
- Reset values: state IDLE, mem_req 0, LOAD_IR 0, INCR_PC 0, LOAD_PC 0, LOAD_ACC 0, alu_op 0, halted 0, fault 0, retired 0, watchdog 0.
- All outputs are decoded from registered state plus mem_ack/zero. mem_ack and zero are the only combinational input-to-output paths.
- Minimum instruction time is 3 cycles when mem_ack is high on the first FETCH cycle. Each extra wait cycle adds 1.
- Strobes are sampled by the PC/IR/ACC registers at the posedge ending the cycle in which they are high. Example: the PC shows +1 on the cycle DECODE is entered.
- IDLE to first mem_req: 1 cycle after run is seen high.
- Timeout: with no ack, mem_req stays high for exactly TIMEOUT cycles. fault and halted are high from the next cycle.
- run deasserted mid-instruction does not abort; the current instruction completes, then the FSM enters IDLE.
- Reset asserted in any state, including mid-FETCH with mem_req high, clears everything asynchronously. No strobe may be emitted in the cycle after reset release.

## Test plan
- Reset, run=1, ack immediate, op sequence 0x0,0x3,0x0 -> mem_req at cycles 1,4,7; INCR_PC with each ack; LOAD_ACC with alu_op=3 once; retired=3; PC advances 0->3.
- JMP: IR=0x85 at PC=2 -> INCR_PC in FETCH, LOAD_PC in EXEC; PC=5 at next FETCH; never both strobes in one cycle.
- JZ/JNZ with zero=1: op 0x9 -> LOAD_PC=1; op 0xA -> LOAD_PC=0, next fetch at PC+1.
- TIMEOUT=4, mem_ack held 0 -> mem_req high 4 cycles, then halted=1, fault=1, INCR_PC never asserted, retired unchanged.
- Illegal op 0xC -> halted=1, fault=1, retired unchanged. Op 0xF -> halted=1, fault=0, retired+1. Outputs remain constant for 20 more cycles.
- 256 NOPs -> retired wraps to 0. Reset asserted mid-FETCH -> all outputs 0 in the same cycle, IDLE after release.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pc_sequencer
// Purpose : Fetch/decode/execute control FSM driving PC, IR and ACC strobes,
//           with a saturating fetch watchdog and a retired-instruction count.
// Revision: 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mem_ack,
    input  logic [3:0] op,
    input  logic       zero,
    output logic       mem_req,
    output logic       LOAD_IR,
    output logic       INCR_PC,
    output logic       LOAD_PC,
    output logic       LOAD_ACC,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic       fault,
    output logic [7:0] retired
);

    localparam int                c_wd_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);
    localparam logic [c_wd_w-1:0] c_wd_max  = c_wd_w'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_op;
    logic [c_wd_w-1:0]   r_wd;
    logic                r_fault;
    logic [7:0]          r_retired;
    logic                w_illegal;
    logic                w_timeout;
    logic                w_retire;

    assign w_illegal = (r_op >= 4'hB) && (r_op <= 4'hE);
    assign w_timeout = (r_state == S_FETCH) && !mem_ack && (r_wd == c_wd_last);
    assign w_retire  = (r_state == S_EXEC) && !w_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 4'h0;
            r_wd      <= '0;
            r_fault   <= 1'b0;
            r_retired <= 8'h00;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= op;
            end
            // Watchdog saturates at TIMEOUT so it can never wrap back to a safe value.
            if (r_state == S_FETCH) begin
                if (mem_ack) begin
                    r_wd <= '0;
                end else if (r_wd != c_wd_max) begin
                    r_wd <= r_wd + 1'b1;
                end
            end
            if (w_timeout || ((r_state == S_EXEC) && w_illegal)) begin
                r_fault <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + 8'd1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        mem_req  = 1'b0;
        LOAD_IR  = 1'b0;
        INCR_PC  = 1'b0;
        LOAD_PC  = 1'b0;
        LOAD_ACC = 1'b0;
        alu_op   = 3'd0;
        halted   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    LOAD_IR = 1'b1;
                    INCR_PC = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_DECODE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                case (r_op)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        LOAD_ACC = 1'b1;
                        alu_op   = r_op[2:0];
                    end
                    4'h8:    LOAD_PC = 1'b1;
                    4'h9:    LOAD_PC = zero;
                    4'hA:    LOAD_PC = ~zero;
                    default: ;
                endcase
                if ((r_op == 4'hF) || w_illegal) begin
                    w_next = S_HALT;
                end else if (run) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign fault   = r_fault;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_sequencer
// Purpose : Directed self-checking bench; a tiny PC/IR/memory model feeds op.
// Revision: 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    logic       clk;
    logic       reset;
    logic       run;
    logic       mem_ack;
    logic [3:0] op;
    logic       zero;
    logic       mem_req;
    logic       LOAD_IR;
    logic       INCR_PC;
    logic       LOAD_PC;
    logic       LOAD_ACC;
    logic [2:0] alu_op;
    logic       halted;
    logic       fault;
    logic [7:0] retired;

    logic       ack_en;
    int         ack_delay;
    int         wcnt;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] mem [0:15];

    int         n_vec;
    int         n_err;
    int         n_incr, n_ldpc, n_acc, n_both, nfa, cyc;
    logic [2:0] last_alu;
    logic [7:0] fa [0:15];
    logic [17:0] outs;

    pc_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .run(run), .mem_ack(mem_ack), .op(op),
        .zero(zero), .mem_req(mem_req), .LOAD_IR(LOAD_IR), .INCR_PC(INCR_PC),
        .LOAD_PC(LOAD_PC), .LOAD_ACC(LOAD_ACC), .alu_op(alu_op),
        .halted(halted), .fault(fault), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign op      = ir[7:4];
    assign mem_ack = ack_en && (wcnt >= ack_delay);
    assign outs    = {mem_req, LOAD_IR, INCR_PC, LOAD_PC, LOAD_ACC, alu_op,
                      halted, fault, retired};

    // Datapath stand-in: PC, IR and a memory wait-state counter.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pc   <= 8'h00;
            ir   <= 8'h00;
            wcnt <= 0;
        end else begin
            if (LOAD_IR) ir <= mem[pc[3:0]];
            if (INCR_PC) pc <= pc + 8'd1;
            else if (LOAD_PC) pc <= {4'h0, ir[3:0]};
            wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; ack_en = 1'b0; ack_delay = 0; zero = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    task automatic run_prog(input int budget);
        n_incr = 0; n_ldpc = 0; n_acc = 0; n_both = 0; nfa = 0; cyc = -1;
        run = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (halted) begin
                cyc = c;
                break;
            end
            if (INCR_PC) n_incr++;
            if (LOAD_PC) n_ldpc++;
            if (INCR_PC && LOAD_PC) n_both++;
            if (LOAD_ACC) begin n_acc++; last_alu = alu_op; end
            if (LOAD_IR && nfa < 16) begin fa[nfa] = pc; nfa++; end
            tick();
        end
        check_eq("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    task automatic hold_check(input logic [7:0] exp_ret, input logic exp_fault);
        int any_strb;
        int not_halt;
        any_strb = 0; not_halt = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req || LOAD_IR || INCR_PC || LOAD_PC || LOAD_ACC || alu_op != 3'd0) any_strb++;
            if (!halted) not_halt++;
            tick();
        end
        check_eq("hold_strobes", any_strb, 0);
        check_eq("hold_halted", not_halt, 0);
        check_eq("hold_retired", {24'd0, retired}, {24'd0, exp_ret});
        check_eq("hold_fault", {31'd0, fault}, {31'd0, exp_fault});
    endtask

    initial begin
        n_vec = 0; n_err = 0; last_alu = 3'd0;
        clear_mem();

        // NOP, ALU op 3, NOP with immediate ack; run dropped during the third.
        do_reset();
        check_eq("reset_outs", {14'd0, outs}, 32'd0);
        mem[1] = 8'h30;
        ack_en = 1'b1; run = 1'b1;
        n_incr = 0; n_acc = 0; n_both = 0;
        for (int c = 0; c <= 10; c++) begin
            if (c == 7) run = 1'b0;
            check_eq($sformatf("mreq_c%0d", c), {31'd0, mem_req},
                     (c == 1 || c == 4 || c == 7) ? 32'd1 : 32'd0);
            if (INCR_PC) n_incr++;
            if (LOAD_ACC) begin n_acc++; last_alu = alu_op; end
            tick();
        end
        check_eq("seq_retired", {24'd0, retired}, 32'd3);
        check_eq("seq_pc", {24'd0, pc}, 32'd3);
        check_eq("seq_incr", n_incr, 3);
        check_eq("seq_acc", n_acc, 1);
        check_eq("seq_alu", {29'd0, last_alu}, 32'd3);

        // JMP 5 at address 2, then HLT at 5.
        do_reset();
        clear_mem();
        mem[2] = 8'h85; mem[5] = 8'hF0;
        ack_en = 1'b1;
        run_prog(100);
        check_eq("jmp_cycles", cyc, 13);
        check_eq("jmp_nfetch", nfa, 4);
        check_eq("jmp_addrs", {fa[0], fa[1], fa[2], fa[3]}, 32'h00010205);
        check_eq("jmp_both", n_both, 0);
        check_eq("jmp_ldpc", n_ldpc, 1);
        check_eq("jmp_pc", {24'd0, pc}, 32'd6);
        hold_check(8'd4, 1'b0);

        // JZ taken and JNZ not taken with zero=1.
        do_reset();
        clear_mem();
        mem[0] = 8'h93; mem[3] = 8'hA7; mem[4] = 8'hF0;
        ack_en = 1'b1; zero = 1'b1;
        run_prog(100);
        check_eq("jz_cycles", cyc, 10);
        check_eq("jz_addrs", {8'd0, fa[0], fa[1], fa[2]}, 32'h00000304);
        check_eq("jz_ldpc", n_ldpc, 1);
        check_eq("jz_retired", {24'd0, retired}, 32'd3);
        check_eq("jz_pc", {24'd0, pc}, 32'd5);
        zero = 1'b0;

        // Fetch timeout with TIMEOUT=4.
        do_reset();
        run = 1'b1;
        n_incr = 0;
        for (int c = 0; c <= 8; c++) begin
            check_eq($sformatf("to_mreq_c%0d", c), {31'd0, mem_req},
                     (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
            check_eq($sformatf("to_halt_c%0d", c), {30'd0, halted, fault},
                     (c >= 5) ? 32'd3 : 32'd0);
            if (INCR_PC) n_incr++;
            tick();
        end
        check_eq("to_incr", n_incr, 0);
        check_eq("to_retired", {24'd0, retired}, 32'd0);

        // Illegal opcode 0xC after one NOP.
        do_reset();
        clear_mem();
        mem[1] = 8'hC0;
        ack_en = 1'b1;
        run_prog(100);
        check_eq("ill_cycles", cyc, 7);
        check_eq("ill_nfetch", nfa, 2);
        hold_check(8'd1, 1'b1);

        // Three wait states per fetch: one short of the timeout each time.
        do_reset();
        clear_mem();
        mem[3] = 8'hF0;
        ack_en = 1'b1; ack_delay = 3;
        run_prog(100);
        check_eq("ws_cycles", cyc, 25);
        check_eq("ws_incr", n_incr, 4);
        check_eq("ws_fault", {31'd0, fault}, 32'd0);
        check_eq("ws_retired", {24'd0, retired}, 32'd4);

        // 256 NOPs wrap the retired counter, then reset lands mid-FETCH.
        do_reset();
        clear_mem();
        ack_en = 1'b1; run = 1'b1;
        for (int c = 0; c < 772; c++) begin
            if (c == 767) check_eq("wrap_255", {24'd0, retired}, 32'd255);
            if (c == 769) begin
                check_eq("wrap_0", {24'd0, retired}, 32'd0);
                check_eq("wrap_pc", {24'd0, pc}, 32'd0);
            end
            tick();
        end
        check_eq("post_wrap", {24'd0, retired}, 32'd1);
        ack_en = 1'b0;
        check_eq("midfetch_req", {31'd0, mem_req}, 32'd1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_outs", {14'd0, outs}, 32'd0);
        tick();
        reset = 1'b0;
        check_eq("post_rel_outs", {14'd0, outs}, 32'd0);
        tick();
        check_eq("restart_req", {31'd0, mem_req}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
